mac_seq: RTL and testbench

Sequencing controller for the signed `mac` datapath: accepts a run length, streams signed operand pairs through one `mac` instance with a saturating feedback accumulator, and returns one dot-product result per run. It sits between an operand source (valid/ready stream) and a result consumer (valid/ready stream). It is the only owner of the `mac` instance: one pair per cycle, no sharing.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac.sv | 21 ++
 rtl/mac_seq.sv | 107 ++++++++++
 tb/tb_mac_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the signed MAC sequencer.
// Widths, FSM state encoding and saturation limits.
package mac_pkg;

   localparam int M_WIDTH   = 8;
   localparam int A_WIDTH   = 16;
   localparam int LEN_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   localparam logic [A_WIDTH-1:0] ACC_MAX =
      {1'b0, {(A_WIDTH-1){1'b1}}};
   localparam logic [A_WIDTH-1:0] ACC_MIN =
      {1'b1, {(A_WIDTH-1){1'b0}}};

endpackage

// File: rtl/mac.sv
// Signed multiply-accumulate datapath.
// out = in0*in1 + inc, computed one bit wider than the accumulator.
module mac
   import mac_pkg::*;
#(
   parameter int M_WIDTH = mac_pkg::M_WIDTH,
   parameter int A_WIDTH = mac_pkg::A_WIDTH,
   parameter int O_WIDTH = A_WIDTH + 1
) (
   input  logic signed [M_WIDTH-1:0] in0,
   input  logic signed [M_WIDTH-1:0] in1,
   input  logic signed [A_WIDTH-1:0] inc,
   output logic signed [O_WIDTH-1:0] out
);

   logic signed [A_WIDTH-1:0] prod;

   assign prod = A_WIDTH'(in0) * A_WIDTH'(in1);
   assign out  = O_WIDTH'(prod) + O_WIDTH'(inc);

endmodule

// File: rtl/mac_seq.sv
// Run-length sequencer around one mac instance with a
// saturating feedback accumulator and sticky overflow flag.
module mac_seq
   import mac_pkg::*;
#(
   parameter int M_WIDTH   = mac_pkg::M_WIDTH,
   parameter int A_WIDTH   = mac_pkg::A_WIDTH,
   parameter int LEN_WIDTH = mac_pkg::LEN_WIDTH
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 busy,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [M_WIDTH-1:0]   s_a,
   input  logic [M_WIDTH-1:0]   s_b,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [A_WIDTH-1:0]   m_data,
   output logic                 m_sat
);

   localparam int O_WIDTH = A_WIDTH + 1;
   localparam logic [A_WIDTH-1:0] SAT_MAX =
      {1'b0, {(A_WIDTH-1){1'b1}}};
   localparam logic [A_WIDTH-1:0] SAT_MIN =
      {1'b1, {(A_WIDTH-1){1'b0}}};

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [A_WIDTH-1:0]   acc_q, acc_d;
   logic                 sat_q, sat_d;

   logic [O_WIDTH-1:0]   sum;
   logic                 ovf;
   logic [A_WIDTH-1:0]   sum_sat;

   mac #(
      .M_WIDTH (M_WIDTH),
      .A_WIDTH (A_WIDTH),
      .O_WIDTH (O_WIDTH)
   ) u_mac (
      .in0 (s_a),
      .in1 (s_b),
      .inc (acc_q),
      .out (sum)
   );

   // Top two sum bits disagree: the step left the accumulator range.
   assign ovf     = sum[A_WIDTH] ^ sum[A_WIDTH-1];
   assign sum_sat = !ovf ? sum[A_WIDTH-1:0] :
                    (sum[A_WIDTH] ? SAT_MIN : SAT_MAX);

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d   = len;
               acc_d   = '0;
               sat_d   = 1'b0;
               state_d = (len == '0) ? ST_OUT : ST_RUN;
            end
         end
         ST_RUN: begin
            if (s_valid) begin
               acc_d = sum_sat;
               sat_d = sat_q | ovf;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LEN_WIDTH'(1))
                  state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (m_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy    = (state_q != ST_IDLE);
   assign s_ready = (state_q == ST_RUN);
   assign m_valid = (state_q == ST_OUT);
   assign m_data  = m_valid ? acc_q : '0;
   assign m_sat   = m_valid & sat_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed self-checking bench for mac_seq.
// Hand-computed dot products, saturation, stalls and reset abort.
module tb_mac_seq;

   logic        ap_clk;
   logic        ap_rst;
   logic        start;
   logic [7:0]  len;
   logic        busy;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_a;
   logic [7:0]  s_b;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        m_sat;

   int checks;
   int failures;
   int lat;
   int va[8];
   int vb[8];

   mac_seq dut (
      .ap_clk  (ap_clk),
      .ap_rst  (ap_rst),
      .start   (start),
      .len     (len),
      .busy    (busy),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_a     (s_a),
      .s_b     (s_b),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_sat   (m_sat)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // Start a run of n pairs from va/vb with gap idle cycles
   // between beats; returns cycles from start to m_valid.
   task automatic run(input int n, input int gap,
                      output int cyc);
      start = 1'b1;
      len   = 8'(n);
      tick();
      cyc   = 1;
      start = 1'b0;
      len   = 8'hAA;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_a = 8'(va[i]);
         s_b = 8'(vb[i]);
         tick();
         cyc++;
         if (gap > 0 && i < n - 1) begin
            s_valid = 1'b0;
            s_a = 8'h55;
            s_b = 8'h55;
            for (int g = 0; g < gap; g++) begin
               tick();
               cyc++;
            end
         end
      end
      s_valid = 1'b0;
      while (!m_valid && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic drain();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("drain_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      ap_rst   = 1'b1;
      start    = 1'b0;
      len      = '0;
      s_valid  = 1'b0;
      s_a      = '0;
      s_b      = '0;
      m_ready  = 1'b0;
      tick();
      chk("rst_busy",   {31'd0, busy},    32'd0);
      chk("rst_sready", {31'd0, s_ready}, 32'd0);
      chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
      chk("rst_mdata",  {16'd0, m_data},  32'd0);
      chk("rst_msat",   {31'd0, m_sat},   32'd0);
      ap_rst = 1'b0;
      tick();

      va[0] = 1;  vb[0] = 2;
      va[1] = 3;  vb[1] = 4;
      va[2] = -5; vb[2] = 6;
      run(3, 0, lat);
      chk("basic_lat",  lat, 4);
      chk("basic_data", {16'd0, m_data}, 32'h0000FFF0);
      chk("basic_sat",  {31'd0, m_sat}, 32'd0);
      drain();

      for (int i = 0; i < 4; i++) begin
         va[i] = 127;
         vb[i] = 127;
      end
      run(3, 0, lat);
      chk("psat_data", {16'd0, m_data}, 32'h00007FFF);
      chk("psat_sat",  {31'd0, m_sat}, 32'd1);
      drain();

      va[3] = -1; vb[3] = 1;
      run(4, 0, lat);
      chk("psat2_data", {16'd0, m_data}, 32'h00007FFE);
      chk("psat2_sat",  {31'd0, m_sat}, 32'd1);
      drain();

      for (int i = 0; i < 3; i++) begin
         va[i] = -128;
         vb[i] = 127;
      end
      run(3, 0, lat);
      chk("nsat_data", {16'd0, m_data}, 32'h00008000);
      chk("nsat_sat",  {31'd0, m_sat}, 32'd1);
      drain();

      run(0, 0, lat);
      chk("empty_lat",  lat, 1);
      chk("empty_data", {16'd0, m_data}, 32'd0);
      chk("empty_sat",  {31'd0, m_sat}, 32'd0);
      drain();

      start = 1'b1;
      len   = 8'd2;
      tick();
      chk("ign_sready", {31'd0, s_ready}, 32'd1);
      len     = 8'd5;
      s_valid = 1'b1;
      s_a = 8'd2;
      s_b = 8'd3;
      tick();
      start = 1'b0;
      s_a = 8'd4;
      s_b = 8'd5;
      tick();
      s_valid = 1'b0;
      chk("ign_mvalid", {31'd0, m_valid}, 32'd1);
      chk("ign_data", {16'd0, m_data}, 32'd26);
      drain();

      va[0] = 2; vb[0] = 3;
      va[1] = 4; vb[1] = 5;
      run(2, 3, lat);
      chk("bp_lat", lat, 6);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
         chk("bp_hold_data", {16'd0, m_data}, 32'd26);
         tick();
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("bp_idle_busy", {31'd0, busy}, 32'd0);
      chk("bp_idle_valid", {31'd0, m_valid}, 32'd0);

      start = 1'b1;
      len   = 8'd3;
      tick();
      start   = 1'b0;
      s_valid = 1'b1;
      s_a = 8'd9;
      s_b = 8'd9;
      tick();
      s_valid = 1'b0;
      ap_rst  = 1'b1;
      #1;
      chk("mrst_busy",   {31'd0, busy},    32'd0);
      chk("mrst_sready", {31'd0, s_ready}, 32'd0);
      chk("mrst_mvalid", {31'd0, m_valid}, 32'd0);
      chk("mrst_mdata",  {16'd0, m_data},  32'd0);
      chk("mrst_msat",   {31'd0, m_sat},   32'd0);
      tick();
      ap_rst = 1'b0;
      tick();
      chk("mrst_no_stale", {31'd0, m_valid}, 32'd0);
      va[0] = 7; vb[0] = 7;
      run(1, 0, lat);
      chk("mrst_lat",  lat, 2);
      chk("mrst_data", {16'd0, m_data}, 32'd49);
      chk("mrst_sat",  {31'd0, m_sat}, 32'd0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
